// File: rtl/signext_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a shared N-to-M sign extender,
// with a registered valid/ready output. Define SIGNEXT_RR_ARBITER_ZEXT_EN for per-request zero-extension.
module signext_rr_arbiter #(
  parameter int unsigned N = 12,
  parameter int unsigned M = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req0_valid,
  output logic         o_req0_ready,
  input  logic [N-1:0] i_req0_x,
  input  logic         i_req1_valid,
  output logic         o_req1_ready,
  input  logic [N-1:0] i_req1_x,
`ifdef SIGNEXT_RR_ARBITER_ZEXT_EN
  input  logic         i_req0_zext,
  input  logic         i_req1_zext,
`endif
  output logic         o_y_valid,
  input  logic         i_y_ready,
  output logic [M-1:0] o_y,
  output logic         o_y_id
);

  logic         last_q;
  logic         y_valid_q;
  logic         y_id_q;
  logic [M-1:0] y_q;

  logic         can_load;
  logic         gnt0;
  logic         gnt1;
  logic         load;
  logic [N-1:0] sel_x;
  logic         sel_zext;
  logic [M-1:0] ext;

  // Grants are suppressed in reset so neither requester sees a spurious accept.
  always_comb begin
    can_load = !y_valid_q || i_y_ready;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    if (i_rst_n && can_load) begin
      if (i_req0_valid && i_req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = i_req0_valid;
        gnt1 = i_req1_valid;
      end
    end
  end

  assign load         = gnt0 || gnt1;
  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  always_comb begin
    sel_x = gnt1 ? i_req1_x : i_req0_x;
`ifdef SIGNEXT_RR_ARBITER_ZEXT_EN
    sel_zext = gnt1 ? i_req1_zext : i_req0_zext;
`else
    sel_zext = 1'b0;
`endif
    // Fill the whole word first, then overlay the low bits; this also covers N == M.
    ext        = sel_zext ? '0 : {M{sel_x[N-1]}};
    ext[N-1:0] = sel_x;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      y_valid_q <= 1'b0;
      y_q       <= '0;
      y_id_q    <= 1'b0;
      last_q    <= 1'b1;
    end else if (load) begin
      y_valid_q <= 1'b1;
      y_q       <= ext;
      y_id_q    <= gnt1;
      last_q    <= gnt1;
    end else if (i_y_ready) begin
      y_valid_q <= 1'b0;
    end
  end

  assign o_y_valid = y_valid_q;
  assign o_y       = y_q;
  assign o_y_id    = y_id_q;

endmodule
